// File: rtl/alu_seq_pkg.sv
// Shared types and record layout for the ALU vector sequencer.
// A record is four bytes {opcode, operand 1, operand 2, expected result}.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EVAL  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

  localparam int OFF_OPC      = 0;
  localparam int OFF_V1       = 1;
  localparam int OFF_V2       = 2;
  localparam int OFF_EXP      = 3;
  localparam int REC_BYTES    = 4;
  localparam int FETCH_CYCLES = 5;
  localparam logic [7:0] SENTINEL = 8'hFF;

  function automatic logic rec_is_sentinel(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
    return (b0 == SENTINEL) && (b1 == SENTINEL) && (b2 == SENTINEL) && (b3 == SENTINEL);
  endfunction

endpackage

// File: rtl/alu_rec_fetch.sv
// Reads one 4-byte record from a synchronous-read byte memory.
// go loads the base address; five cycles later the record is held in byte_q.
module alu_rec_fetch
  import alu_seq_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        rec_opc,
  output logic [7:0]        rec_v1,
  output logic [7:0]        rec_v2,
  output logic [7:0]        rec_exp,
  output logic              rec_valid,
  output logic              is_sentinel
);

  logic              active_q, active_d;
  logic [2:0]        k_q, k_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        byte_q [REC_BYTES];
  logic [7:0]        byte_d [REC_BYTES];
  logic [1:0]        cap_idx;

  // Data for address base+k-1 arrives in cycle k, one behind the address.
  assign cap_idx = 2'(k_q - 3'd1);

  always_comb begin
    active_d = active_q;
    k_d      = k_q;
    addr_d   = addr_q;
    for (int i = 0; i < REC_BYTES; i++) byte_d[i] = byte_q[i];
    if (go) begin
      active_d = 1'b1;
      k_d      = 3'd0;
      addr_d   = base_addr;
    end else if (active_q) begin
      if (k_q != 3'd0) byte_d[cap_idx] = mem_rdata;
      if (k_q < 3'(REC_BYTES - 1)) addr_d = addr_q + ADDR_W'(1);
      if (k_q == 3'(FETCH_CYCLES - 1)) active_d = 1'b0;
      else k_d = k_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      k_q      <= '0;
      addr_q   <= '0;
      for (int i = 0; i < REC_BYTES; i++) byte_q[i] <= '0;
    end else begin
      active_q <= active_d;
      k_q      <= k_d;
      addr_q   <= addr_d;
      for (int i = 0; i < REC_BYTES; i++) byte_q[i] <= byte_d[i];
    end
  end

  assign mem_addr    = addr_q;
  assign rec_valid   = active_q && (k_q == 3'(FETCH_CYCLES - 1));
  assign rec_opc     = byte_q[OFF_OPC][2:0];
  assign rec_v1      = byte_q[OFF_V1];
  assign rec_v2      = byte_q[OFF_V2];
  assign rec_exp     = byte_q[OFF_EXP];
  assign is_sentinel = rec_is_sentinel(byte_q[OFF_OPC], byte_q[OFF_V1],
                                       byte_q[OFF_V2], byte_q[OFF_EXP]);

endmodule

// File: rtl/alu_vector_sequencer.sv
// On-chip ALU self-test: walks vector records, drives the ALU and scores the results.
// state | meaning
// IDLE  | waiting for start
// FETCH | reading the 4 bytes of the current record
// EVAL  | sentinel test, then ALU inputs and expected byte are loaded
// CHECK | ALU result compared with expected byte, counters updated
// DONE  | run finished, counters held until next start
module alu_vector_sequencer
  import alu_seq_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int DEPTH     = 64,
  parameter int MAX_TESTS = 10,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [2:0]        alu_opc,
  output logic [7:0]        alu_v1,
  output logic [7:0]        alu_v2,
  input  logic [7:0]        alu_out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  test_num,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              fail_pulse,
  output logic [CNT_W-1:0]  fail_index
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  test_num_q, test_num_d;
  logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0]  fail_index_q, fail_index_d;
  logic [2:0]        opc_q, opc_d;
  logic [7:0]        v1_q, v1_d;
  logic [7:0]        v2_q, v2_d;
  logic [7:0]        exp_q, exp_d;
  logic              fetch_go;
  logic              last_rec;
  logic              rec_valid;
  logic              is_sentinel;
  logic [2:0]        rec_opc;
  logic [7:0]        rec_v1, rec_v2, rec_exp;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  alu_rec_fetch #(.ADDR_W(ADDR_W)) u_fetch (
    .clk         (clk),
    .rst         (rst),
    .go          (fetch_go),
    .base_addr   (base_d),
    .mem_rdata   (mem_rdata),
    .mem_addr    (mem_addr),
    .rec_opc     (rec_opc),
    .rec_v1      (rec_v1),
    .rec_v2      (rec_v2),
    .rec_exp     (rec_exp),
    .rec_valid   (rec_valid),
    .is_sentinel (is_sentinel)
  );

  // Stop when the cap is reached or the following record would run past the memory.
  assign last_rec = (int'(test_num_q) + 1 == MAX_TESTS) ||
                    (int'(base_q) + 2 * REC_BYTES - 1 > DEPTH - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q       <= '0;
      test_num_q   <= '0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      fail_index_q <= '0;
      opc_q        <= '0;
      v1_q         <= '0;
      v2_q         <= '0;
      exp_q        <= '0;
    end else begin
      base_q       <= base_d;
      test_num_q   <= test_num_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      fail_index_q <= fail_index_d;
      opc_q        <= opc_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      exp_q        <= exp_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    test_num_d   = test_num_q;
    pass_cnt_d   = pass_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    fail_index_d = fail_index_q;
    opc_d        = opc_q;
    v1_d         = v1_q;
    v2_d         = v2_q;
    exp_d        = exp_q;
    fetch_go     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = FETCH;
          base_d       = '0;
          test_num_d   = '0;
          pass_cnt_d   = '0;
          fail_cnt_d   = '0;
          fail_index_d = '0;
          fetch_go     = 1'b1;
        end
      end
      FETCH: begin
        if (rec_valid) state_d = EVAL;
      end
      EVAL: begin
        if (is_sentinel) begin
          state_d = DONE;
        end else begin
          opc_d   = rec_opc;
          v1_d    = rec_v1;
          v2_d    = rec_v2;
          exp_d   = rec_exp;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (alu_out == exp_q) begin
          pass_cnt_d = sat_inc(pass_cnt_q);
        end else begin
          fail_cnt_d   = sat_inc(fail_cnt_q);
          fail_index_d = test_num_q;
        end
        test_num_d = sat_inc(test_num_q);
        base_d     = base_q + ADDR_W'(REC_BYTES);
        if (last_rec) begin
          state_d = DONE;
        end else begin
          state_d  = FETCH;
          fetch_go = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    fail_pulse = 1'b0;
    case (state_q)
      FETCH, EVAL: busy = 1'b1;
      CHECK: begin
        busy       = 1'b1;
        fail_pulse = (alu_out != exp_q);
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign alu_opc    = opc_q;
  assign alu_v1     = v1_q;
  assign alu_v2     = v2_q;
  assign test_num   = test_num_q;
  assign pass_cnt   = pass_cnt_q;
  assign fail_cnt   = fail_cnt_q;
  assign fail_index = fail_index_q;

endmodule

// File: tb/tb_alu_vector_sequencer.sv
// Bench for alu_vector_sequencer: three instances (DEPTH 64, 8, 7) share one vector image;
// results are compared with a record-level model of the run.
module tb_alu_vector_sequencer;

  localparam int NI   = 3;
  localparam int MAXT = 10;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic [7:0] mem [64];

  logic [5:0] addr_w [NI];
  logic [2:0] opc_w  [NI];
  logic [7:0] v1_w [NI], v2_w [NI], tn_w [NI], pc_w [NI], fc_w [NI], fi_w [NI];
  logic       busy_w [NI], done_w [NI], fp_w [NI];

  int n_checks = 0;
  int n_pass   = 0;
  int m_n [NI], m_pass [NI], m_fail [NI], m_fidx [NI], m_cyc [NI], m_maxa [NI];
  int e_opc [NI], e_v1 [NI], e_v2 [NI];

  always #5 clk = ~clk;

  function automatic int depth_of(input int i);
    return (i == 0) ? 64 : ((i == 1) ? 8 : 7);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [5:0] mem_addr;
    logic [7:0] mem_rdata = 8'h00;
    logic [2:0] alu_opc;
    logic [7:0] alu_v1, alu_v2, alu_out, test_num, pass_cnt, fail_cnt, fail_index;
    logic       busy, done, fail_pulse;

    always @(posedge clk) mem_rdata <= mem[mem_addr];
    assign alu_out = alu_v1 + alu_v2;

    alu_vector_sequencer #(
      .ADDR_W(6), .DEPTH((g == 0) ? 64 : ((g == 1) ? 8 : 7)), .MAX_TESTS(MAXT), .CNT_W(8)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .alu_opc    (alu_opc),
      .alu_v1     (alu_v1),
      .alu_v2     (alu_v2),
      .alu_out    (alu_out),
      .busy       (busy),
      .done       (done),
      .test_num   (test_num),
      .pass_cnt   (pass_cnt),
      .fail_cnt   (fail_cnt),
      .fail_pulse (fail_pulse),
      .fail_index (fail_index)
    );

    assign addr_w[g] = mem_addr;
    assign opc_w[g]  = alu_opc;
    assign v1_w[g]   = alu_v1;
    assign v2_w[g]   = alu_v2;
    assign tn_w[g]   = test_num;
    assign pc_w[g]   = pass_cnt;
    assign fc_w[g]   = fail_cnt;
    assign fi_w[g]   = fail_index;
    assign busy_w[g] = busy;
    assign done_w[g] = done;
    assign fp_w[g]   = fail_pulse;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Record-level model: walk the image, stop on sentinel, cap or end of memory.
  task automatic model_all();
    for (int i = 0; i < NI; i++) begin
      int base;
      bit fin;
      base = 0;
      fin  = 1'b0;
      m_n[i] = 0; m_pass[i] = 0; m_fail[i] = 0; m_fidx[i] = 0; m_cyc[i] = 0; m_maxa[i] = 0;
      while (!fin) begin
        m_maxa[i] = base + 3;
        if (mem[base] == 8'hFF && mem[base+1] == 8'hFF &&
            mem[base+2] == 8'hFF && mem[base+3] == 8'hFF) begin
          m_cyc[i] += 6;
          fin = 1'b1;
        end else begin
          e_opc[i] = int'(mem[base]) % 8;
          e_v1[i]  = int'(mem[base+1]);
          e_v2[i]  = int'(mem[base+2]);
          if ((e_v1[i] + e_v2[i]) % 256 == int'(mem[base+3])) m_pass[i]++;
          else begin
            m_fail[i]++;
            m_fidx[i] = m_n[i];
          end
          m_n[i]++;
          m_cyc[i] += 7;
          if (m_n[i] == MAXT || base + 8 > depth_of(i)) fin = 1'b1;
          else base += 4;
        end
      end
    end
  endtask

  task automatic put_rec(input int r, input int b0, input int b1, input int b2, input int b3);
    mem[4*r]   = 8'(b0);
    mem[4*r+1] = 8'(b1);
    mem[4*r+2] = 8'(b2);
    mem[4*r+3] = 8'(b3);
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 64; a++) mem[a] = 8'h00;
  endtask

  task automatic fill_pass();
    for (int r = 0; r < 16; r++) begin
      int a, b;
      a = int'($urandom_range(1, 200));
      b = int'($urandom_range(0, 255));
      put_rec(r, int'($urandom_range(0, 254)), a, b, (a + b) % 256);
    end
  endtask

  task automatic fill_random();
    int s;
    for (int r = 0; r < 16; r++) begin
      int a, b, x;
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      x = ($urandom_range(0, 9) < 7) ? (a + b) % 256 : (a + b + int'($urandom_range(1, 255))) % 256;
      put_rec(r, int'($urandom_range(0, 254)), a, b, x);
    end
    s = int'($urandom_range(0, 16));
    if (s < 16) put_rec(s, 255, 255, 255, 255);
  endtask

  task automatic run_check(input string tag, input bit hold_start);
    int  cyc;
    bit  all_done;
    int  dcyc [NI];
    int  fpc  [NI];
    int  maxa [NI];
    model_all();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < NI; i++) begin
      dcyc[i] = -1;
      fpc[i]  = 0;
      maxa[i] = int'(addr_w[i]);
      check_eq($sformatf("%s/d%0d/busy_on", tag, i), int'(busy_w[i]), 1);
    end
    cyc      = 0;
    all_done = 1'b0;
    while (!all_done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      start    = hold_start && (cyc <= 6);
      all_done = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (dcyc[i] < 0) begin
          if (done_w[i]) dcyc[i] = cyc;
          else begin
            all_done = 1'b0;
            if (fp_w[i]) fpc[i]++;
            if (int'(addr_w[i]) > maxa[i]) maxa[i] = int'(addr_w[i]);
          end
        end
      end
    end
    start = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("%s/d%0d/done_cycle", tag, i), dcyc[i], m_cyc[i]);
      check_eq($sformatf("%s/d%0d/busy_off", tag, i), int'(busy_w[i]), 0);
      check_eq($sformatf("%s/d%0d/test_num", tag, i), int'(tn_w[i]), m_n[i]);
      check_eq($sformatf("%s/d%0d/pass_cnt", tag, i), int'(pc_w[i]), m_pass[i]);
      check_eq($sformatf("%s/d%0d/fail_cnt", tag, i), int'(fc_w[i]), m_fail[i]);
      check_eq($sformatf("%s/d%0d/fail_index", tag, i), int'(fi_w[i]), m_fidx[i]);
      check_eq($sformatf("%s/d%0d/fail_pulses", tag, i), fpc[i], m_fail[i]);
      check_eq($sformatf("%s/d%0d/max_addr", tag, i), maxa[i], m_maxa[i]);
      check_eq($sformatf("%s/d%0d/alu_opc", tag, i), int'(opc_w[i]), e_opc[i]);
      check_eq($sformatf("%s/d%0d/alu_v1", tag, i), int'(v1_w[i]), e_v1[i]);
      check_eq($sformatf("%s/d%0d/alu_v2", tag, i), int'(v2_w[i]), e_v2[i]);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("%s/d%0d/busy", tag, i), int'(busy_w[i]), 0);
      check_eq($sformatf("%s/d%0d/done", tag, i), int'(done_w[i]), 0);
      check_eq($sformatf("%s/d%0d/addr", tag, i), int'(addr_w[i]), 0);
      check_eq($sformatf("%s/d%0d/test_num", tag, i), int'(tn_w[i]), 0);
      check_eq($sformatf("%s/d%0d/pass_cnt", tag, i), int'(pc_w[i]), 0);
      check_eq($sformatf("%s/d%0d/fail_cnt", tag, i), int'(fc_w[i]), 0);
      check_eq($sformatf("%s/d%0d/fail_index", tag, i), int'(fi_w[i]), 0);
      check_eq($sformatf("%s/d%0d/alu_v1", tag, i), int'(v1_w[i]), 0);
      check_eq($sformatf("%s/d%0d/alu_opc", tag, i), int'(opc_w[i]), 0);
      check_eq($sformatf("%s/d%0d/fail_pulse", tag, i), int'(fp_w[i]), 0);
      e_opc[i] = 0;
      e_v1[i]  = 0;
      e_v2[i]  = 0;
    end
  endtask

  initial begin
    clear_mem();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    put_rec(0, 8'h00, 8'h05, 8'h03, 8'h08);
    put_rec(1, 255, 255, 255, 255);
    run_check("pass_one", 1'b0);

    clear_mem();
    put_rec(0, 8'h01, 8'h10, 8'h20, 8'h31);
    put_rec(1, 255, 255, 255, 255);
    run_check("fail_one", 1'b0);

    fill_pass();
    run_check("cap", 1'b0);
    run_check("start_held", 1'b1);
    run_check("restart", 1'b0);

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    for (int i = 0; i < NI; i++)
      check_eq($sformatf("pre_rst/d%0d/test_num", i), int'(tn_w[i]), 1);
    #2 rst = 1'b1;
    #1 check_zero("mid_rst");
    @(negedge clk); rst = 1'b0;
    run_check("after_rst", 1'b0);

    for (int t = 0; t < 8; t++) begin
      fill_random();
      run_check($sformatf("rand%0d", t), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
